sap_datapath: RTL and testbench
===============================

# sap_datapath

Datapath for the SAP-1 CPU: the 8-bit bus plus the A and B registers, adder/subtractor, memory address register, 16×8 RAM, instruction register, program counter and output register. It sits directly downstream of the control sequencer and consumes its per-cycle control word. The sequencer changes controls on the falling edge; this block acts on them on the rising edge. It returns the current opcode nibble to the sequencer.

## Interface
- `DATA_W`, default 8: bus, register and RAM word width.
- `ADDR_W`, default 4: PC, MAR and RAM address width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `halt`, `maddr_latch`, `ram_latch`, `ram_out`, `instruction_latch`, `instruction_out`, `a_reg_latch`, `a_reg_out`, `alu_out`, `alu_sub`, `b_reg_latch`, `output_latch`, `counter_enable`, `counter_out` in 1 each: control strobes from the sequencer.
- `prog_we` in 1: external RAM program-load write.
- `prog_addr` in ADDR_W: program-load address.
- `prog_data` in DATA_W: program-load data.
- `instruction` out 4: IR[7:4], the opcode sent to the sequencer.
- `out_value` out DATA_W: output register contents.
- `bus_value` out DATA_W: current bus value (combinational).
- `halted` out 1: sticky halt indicator.
- `bus_conflict` out 1: combinational; high when more than one bus driver is enabled.

## Operation
- **Bus sources**, fixed priority: `ram_out` (RAM[MAR]), then `instruction_out` ({0, IR[3:0]}), then `a_reg_out` (A), then `alu_out` (ALU result), then `counter_out` ({0, PC}). With no source enabled, the bus reads 0x00.
- **`bus_conflict`**: asserted when two or more source enables are high. The highest-priority source still drives the bus.
- **ALU**: combinational. `alu_sub`=0 gives A+B; `alu_sub`=1 gives A+~B+1. Results are modulo 2^DATA_W.
- **Latches**, each on the rising edge while its strobe is high: `maddr_latch` gives MAR←bus[ADDR_W-1:0]; `ram_latch` gives RAM[MAR]←bus; `instruction_latch` gives IR←bus; `a_reg_latch` gives A←bus; `b_reg_latch` gives B←bus; `output_latch` gives OUT←bus.
- **PC**: `counter_enable` increments the PC. It wraps 15→0 with no flag.
- **Same-edge events**: every bus source uses pre-edge state. Examples: `maddr_latch`+`ram_out` reads RAM at the old MAR. `counter_out`+`counter_enable` drives the old PC. `alu_out`+`a_reg_latch` loads A with the sum of the old A and B.
- **Write collision**: `prog_we` has priority over `ram_latch`. When both are high, only the `prog_we` write occurs.
- **Halt**: `halt` high on a rising edge sets `halted`. The same edge and every later edge suppress all latches and PC increments. `prog_we` still works while halted. Only `reset` clears `halted`.
- **Reset**: A, B, IR, PC, MAR, OUT and `halted` are cleared to 0. RAM is not cleared. `reset` has priority over every strobe, including on the edge where it is asserted mid-instruction.

## Timing
- Every register and RAM write takes effect on the edge where its strobe is sampled high. The new value is visible in the following cycle.
- The bus, ALU result, `bus_conflict` and `instruction` are combinational from current state and controls. They have zero latency.
- RAM reads are asynchronous (combinational from MAR).
- After reset, `instruction`=0, `out_value`=0x00, `halted`=0, `bus_value`=0x00 and `bus_conflict`=0.

## Configuration
- **`SAP_FLAGS_EN` defined**:
  - adds outputs `carry_flag` and `zero_flag`, 1 bit each, reset to 0;
  - both update only on an edge where `alu_out` and `a_reg_latch` are both high and the block is not halted;
  - carry = carry-out of the DATA_W-bit add (including the +1 for subtract);
  - zero = (result == 0).
- **`SAP_FLAGS_EN` undefined**: the ports and flag registers are absent; all other behaviour is identical.

## Structure
- **Package `sap_pkg`**: DATA_W and ADDR_W defaults, RAM depth (2^ADDR_W), opcode constants (LDA=4'b0001, ADD=4'b0010, OUT=4'b1110), and the control-word bit positions shared with the sequencer.
- **Sub-module `sap_alu`**: combinational add/subtract returning the result and carry-out.
- **Top level**: RAM, registers, bus mux and conflict detector live in `sap_datapath` itself.

## Test plan
1. **Reset**: assert `reset` with `a_reg_latch`=1 and bus driven. Expect A=0, PC=0, `instruction`=0, `out_value`=0, `halted`=0.
2. **Fetch**:
   - Preload RAM[0]=0x1E via `prog_we`, then assert `maddr_latch`+`counter_out`+`counter_enable` for one edge. Expect MAR=0, PC=1.
   - Then assert `ram_out`+`instruction_latch`. Expect `instruction`=4'h1; `instruction_out` then drives bus=0x0E.
3. **ALU**:
   - A=0x1C, B=0x0E, assert `alu_out`+`a_reg_latch`. Expect A=0x2A (carry=0, zero=0 with flags).
   - A=0x05, B=0x07 with `alu_sub`. Expect A=0xFE, carry=0.
   - A=0x07, B=0x07 with `alu_sub`. Expect A=0x00, carry=1, zero=1.
4. **PC wrap**: drive PC to 15, assert `counter_enable`. Expect PC=0 and `counter_out` bus=0x00.
5. **Bus conflict**: RAM[MAR]=0x55, A=0xAA, assert `ram_out`+`a_reg_out`+`output_latch`. Expect `bus_conflict`=1 and `out_value`=0x55.
6. **Halt**: assert `halt`+`a_reg_latch` with bus=0x33 and A=0x10. Expect A stays 0x10, `halted`=1 and remaining 1 after `halt` drops. PC is frozen under `counter_enable`. `reset` clears `halted`.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared SAP-1 constants: default widths, opcodes and the sequencer control-word layout.
package sap_pkg;

  localparam int unsigned SAP_DATA_W    = 8;
  localparam int unsigned SAP_ADDR_W    = 4;
  localparam int unsigned SAP_RAM_DEPTH = 1 << SAP_ADDR_W;
  localparam int unsigned SAP_OP_W      = 4;

  localparam logic [SAP_OP_W-1:0] OP_LDA = 4'b0001;
  localparam logic [SAP_OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [SAP_OP_W-1:0] OP_OUT = 4'b1110;

  // Control-word bit positions as packed by the sequencer (MSB first).
  localparam int unsigned CW_W                 = 14;
  localparam int unsigned CW_HALT              = 13;
  localparam int unsigned CW_MADDR_LATCH       = 12;
  localparam int unsigned CW_RAM_LATCH         = 11;
  localparam int unsigned CW_RAM_OUT           = 10;
  localparam int unsigned CW_INSTRUCTION_LATCH = 9;
  localparam int unsigned CW_INSTRUCTION_OUT   = 8;
  localparam int unsigned CW_A_REG_LATCH       = 7;
  localparam int unsigned CW_A_REG_OUT         = 6;
  localparam int unsigned CW_ALU_OUT           = 5;
  localparam int unsigned CW_ALU_SUB           = 4;
  localparam int unsigned CW_B_REG_LATCH       = 3;
  localparam int unsigned CW_OUTPUT_LATCH      = 2;
  localparam int unsigned CW_COUNTER_ENABLE    = 1;
  localparam int unsigned CW_COUNTER_OUT       = 0;

  typedef struct packed {
    logic halt;
    logic maddr_latch;
    logic ram_latch;
    logic ram_out;
    logic instruction_latch;
    logic instruction_out;
    logic a_reg_latch;
    logic a_reg_out;
    logic alu_out;
    logic alu_sub;
    logic b_reg_latch;
    logic output_latch;
    logic counter_enable;
    logic counter_out;
  } ctrl_t;

endpackage

// File: rtl/sap_alu.sv
// SAP-1 adder/subtractor: A+B, or A+~B+1 when subtracting, with carry-out.
module sap_alu #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o
);

  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   sum;

  always_comb begin
    b_op = sub_i ? ~b_i : b_i;
    sum  = (DATA_W+1)'(a_i) + (DATA_W+1)'(b_op) + (DATA_W+1)'(sub_i);
  end

  assign result_o = sum[DATA_W-1:0];
  assign carry_o  = sum[DATA_W];

endmodule

// File: rtl/sap_datapath.sv
// SAP-1 datapath: bus, A/B, ALU, MAR, RAM, IR, PC and OUT driven by the sequencer's strobes.
// Define SAP_FLAGS_EN to add carry_flag/zero_flag outputs captured on ALU-to-A transfers.
module sap_datapath
  import sap_pkg::*;
#(
  parameter int unsigned DATA_W = SAP_DATA_W,
  parameter int unsigned ADDR_W = SAP_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic              maddr_latch,
  input  logic              ram_latch,
  input  logic              ram_out,
  input  logic              instruction_latch,
  input  logic              instruction_out,
  input  logic              a_reg_latch,
  input  logic              a_reg_out,
  input  logic              alu_out,
  input  logic              alu_sub,
  input  logic              b_reg_latch,
  input  logic              output_latch,
  input  logic              counter_enable,
  input  logic              counter_out,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        instruction,
  output logic [DATA_W-1:0] out_value,
  output logic [DATA_W-1:0] bus_value,
  output logic              halted,
`ifdef SAP_FLAGS_EN
  output logic              carry_flag,
  output logic              zero_flag,
`endif
  output logic              bus_conflict
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_W;
  localparam int unsigned SRC_N     = 5;

  ctrl_t              ctrl;
  logic [SRC_N-1:0]   src;
  logic               latch_en;
  logic               ram_we;
  logic [DATA_W-1:0]  bus;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_cout;

  logic [DATA_W-1:0]  mem_q [RAM_DEPTH];
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, ir_q, ir_d, out_q, out_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, mar_q, mar_d;
  logic               halted_q, halted_d;

  assign ctrl = '{halt, maddr_latch, ram_latch, ram_out, instruction_latch,
                  instruction_out, a_reg_latch, a_reg_out, alu_out, alu_sub,
                  b_reg_latch, output_latch, counter_enable, counter_out};

  sap_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .sub_i    (ctrl.alu_sub),
    .result_o (alu_res),
    .carry_o  (alu_cout)
  );

  // Fixed-priority bus mux; all sources reflect pre-edge state.
  always_comb begin
    bus = '0;
    if (ctrl.ram_out)              bus = mem_q[mar_q];
    else if (ctrl.instruction_out) bus = DATA_W'(ir_q[3:0]);
    else if (ctrl.a_reg_out)       bus = a_q;
    else if (ctrl.alu_out)         bus = alu_res;
    else if (ctrl.counter_out)     bus = DATA_W'(pc_q);
  end

  // More than one source bit set <=> clearing the lowest set bit leaves something.
  assign src          = {ctrl.ram_out, ctrl.instruction_out, ctrl.a_reg_out,
                         ctrl.alu_out, ctrl.counter_out};
  assign bus_conflict = |(src & (src - SRC_N'(1)));

  // Halt blocks every latch on its own edge as well as all later ones.
  assign latch_en = !ctrl.halt && !halted_q;
  assign ram_we   = !reset && latch_en && ctrl.ram_latch;

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    ir_d     = ir_q;
    out_d    = out_q;
    pc_d     = pc_q;
    mar_d    = mar_q;
    halted_d = halted_q | ctrl.halt;
    if (latch_en) begin
      if (ctrl.a_reg_latch)       a_d   = bus;
      if (ctrl.b_reg_latch)       b_d   = bus;
      if (ctrl.instruction_latch) ir_d  = bus;
      if (ctrl.output_latch)      out_d = bus;
      if (ctrl.maddr_latch)       mar_d = bus[ADDR_W-1:0];
      if (ctrl.counter_enable)    pc_d  = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      ir_q     <= '0;
      out_q    <= '0;
      pc_q     <= '0;
      mar_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      ir_q     <= ir_d;
      out_q    <= out_d;
      pc_q     <= pc_d;
      mar_q    <= mar_d;
      halted_q <= halted_d;
    end
  end

  // Program load wins over a same-edge bus write; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_we)     mem_q[prog_addr] <= prog_data;
    else if (ram_we) mem_q[mar_q]     <= bus;
  end

`ifdef SAP_FLAGS_EN
  logic carry_q, zero_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (latch_en && ctrl.alu_out && ctrl.a_reg_latch) begin
      carry_q <= alu_cout;
      zero_q  <= (alu_res == '0);
    end
  end

  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
`else
  logic carry_unused;
  assign carry_unused = alu_cout;
`endif

  assign instruction = ir_q[DATA_W-1:DATA_W-4];
  assign out_value   = out_q;
  assign bus_value   = bus;
  assign halted      = halted_q;

endmodule

// File: tb/tb_sap_datapath.sv
// Directed bench for sap_datapath: expectations queued at stimulus, popped and asserted at sampling.
module tb_sap_datapath;
  import sap_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       halt, maddr_latch, ram_latch, ram_out, instruction_latch, instruction_out;
  logic       a_reg_latch, a_reg_out, alu_out, alu_sub, b_reg_latch, output_latch;
  logic       counter_enable, counter_out, prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [3:0] instruction;
  logic [7:0] out_value, bus_value;
  logic       halted, bus_conflict;
`ifdef SAP_FLAGS_EN
  logic       carry_flag, zero_flag;
`endif

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  sap_datapath dut (
    .clk               (clk),
    .reset             (reset),
    .halt              (halt),
    .maddr_latch       (maddr_latch),
    .ram_latch         (ram_latch),
    .ram_out           (ram_out),
    .instruction_latch (instruction_latch),
    .instruction_out   (instruction_out),
    .a_reg_latch       (a_reg_latch),
    .a_reg_out         (a_reg_out),
    .alu_out           (alu_out),
    .alu_sub           (alu_sub),
    .b_reg_latch       (b_reg_latch),
    .output_latch      (output_latch),
    .counter_enable    (counter_enable),
    .counter_out       (counter_out),
    .prog_we           (prog_we),
    .prog_addr         (prog_addr),
    .prog_data         (prog_data),
    .instruction       (instruction),
    .out_value         (out_value),
    .bus_value         (bus_value),
    .halted            (halted),
`ifdef SAP_FLAGS_EN
    .carry_flag        (carry_flag),
    .zero_flag         (zero_flag),
`endif
    .bus_conflict      (bus_conflict)
  );

  task automatic clr_ctrl();
    halt = 0; maddr_latch = 0; ram_latch = 0; ram_out = 0;
    instruction_latch = 0; instruction_out = 0; a_reg_latch = 0; a_reg_out = 0;
    alu_out = 0; alu_sub = 0; b_reg_latch = 0; output_latch = 0;
    counter_enable = 0; counter_out = 0; prog_we = 0;
    prog_addr = '0; prog_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [7:0] obs);
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%02h expected=<none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) passed++;
      else $error("FAIL %s observed=%02h expected=%02h", e.tag, obs, e.val);
    end
  endtask

  task automatic expect_now(input string tag, input logic [7:0] exp, input logic [7:0] obs);
    sb_push(tag, exp);
    sb_check(obs);
  endtask

  task automatic peek_a(input string tag, input logic [7:0] exp);
    sb_push(tag, exp);
    a_reg_out = 1; #1;
    sb_check(bus_value);
    a_reg_out = 0; #1;
  endtask

  task automatic peek_pc(input string tag, input logic [7:0] exp);
    sb_push(tag, exp);
    counter_out = 1; #1;
    sb_check(bus_value);
    counter_out = 0; #1;
  endtask

  task automatic peek_ram(input string tag, input logic [7:0] exp);
    sb_push(tag, exp);
    ram_out = 1; #1;
    sb_check(bus_value);
    ram_out = 0; #1;
  endtask

  task automatic prog_write(input logic [3:0] addr, input logic [7:0] data);
    prog_we = 1; prog_addr = addr; prog_data = data;
    tick();
    clr_ctrl();
  endtask

  // MAR stays at 0 after the fetch, so RAM[0] is the staging slot for register loads.
  task automatic load_a(input logic [7:0] v);
    prog_write(4'h0, v);
    ram_out = 1; a_reg_latch = 1;
    tick();
    clr_ctrl();
  endtask

  task automatic load_b(input logic [7:0] v);
    prog_write(4'h0, v);
    ram_out = 1; b_reg_latch = 1;
    tick();
    clr_ctrl();
  endtask

  task automatic alu_to_a(input logic sub);
    alu_out = 1; alu_sub = sub; a_reg_latch = 1;
    tick();
    clr_ctrl();
  endtask

  initial begin
    clr_ctrl();
    reset = 1;
    tick(); tick();
    reset = 0;

    // Dirty A, PC and OUT so that the mid-instruction reset has something to clear.
    prog_write(4'h0, 8'h1E);
    ram_out = 1; a_reg_latch = 1; counter_enable = 1; output_latch = 1;
    tick();
    clr_ctrl();
    peek_a("pre_reset_A", 8'h1E);

    reset = 1;
    ram_out = 1; a_reg_latch = 1; counter_enable = 1; output_latch = 1; instruction_latch = 1;
    tick();
    reset = 0;
    clr_ctrl(); #1;
    expect_now("rst_instruction", 8'h00, 8'(instruction));
    expect_now("rst_out_value", 8'h00, out_value);
    expect_now("rst_halted", 8'h00, 8'(halted));
    expect_now("rst_bus", 8'h00, bus_value);
    expect_now("rst_conflict", 8'h00, 8'(bus_conflict));
`ifdef SAP_FLAGS_EN
    expect_now("rst_carry", 8'h00, 8'(carry_flag));
    expect_now("rst_zero", 8'h00, 8'(zero_flag));
`endif
    peek_a("rst_A", 8'h00);
    peek_pc("rst_PC", 8'h00);

    // Fetch: counter_out drives the pre-increment PC into MAR.
    maddr_latch = 1; counter_out = 1; counter_enable = 1; #1;
    expect_now("fetch_bus_old_pc", 8'h00, bus_value);
    tick();
    clr_ctrl();
    peek_pc("fetch_PC", 8'h01);
    peek_ram("fetch_MAR_ram", 8'h1E);
    ram_out = 1; instruction_latch = 1;
    tick();
    clr_ctrl();
    expect_now("fetch_opcode", 8'(OP_LDA), 8'(instruction));
    instruction_out = 1; #1;
    expect_now("ir_operand_bus", 8'h0E, bus_value);
    instruction_out = 0;

    // ALU add, then two subtracts around the borrow boundary.
    load_a(8'h1C); load_b(8'h0E);
    alu_out = 1; #1;
    expect_now("alu_add_bus", 8'h2A, bus_value);
    alu_out = 0;
    alu_to_a(1'b0);
    peek_a("alu_add_A", 8'h2A);
`ifdef SAP_FLAGS_EN
    expect_now("add_carry", 8'h00, 8'(carry_flag));
    expect_now("add_zero", 8'h00, 8'(zero_flag));
`endif
    load_a(8'h05); load_b(8'h07);
    alu_to_a(1'b1);
    peek_a("alu_sub_neg_A", 8'hFE);
`ifdef SAP_FLAGS_EN
    expect_now("sub_neg_carry", 8'h00, 8'(carry_flag));
    expect_now("sub_neg_zero", 8'h00, 8'(zero_flag));
`endif
    load_a(8'h07); load_b(8'h07);
    alu_to_a(1'b1);
    peek_a("alu_sub_zero_A", 8'h00);
`ifdef SAP_FLAGS_EN
    expect_now("sub_zero_carry", 8'h01, 8'(carry_flag));
    expect_now("sub_zero_zero", 8'h01, 8'(zero_flag));
`endif

    // PC wrap: PC is 1 here.
    counter_enable = 1;
    repeat (14) tick();
    clr_ctrl();
    peek_pc("pc_at_15", 8'h0F);
    counter_enable = 1;
    tick();
    clr_ctrl();
    peek_pc("pc_wrap", 8'h00);

    // Bus conflict: RAM wins over A.
    load_a(8'hAA);
    prog_write(4'h0, 8'h55);
    ram_out = 1; a_reg_out = 1; output_latch = 1; #1;
    expect_now("conflict_flag", 8'h01, 8'(bus_conflict));
    expect_now("conflict_bus", 8'h55, bus_value);
    tick();
    clr_ctrl();
    expect_now("conflict_out", 8'h55, out_value);

    // Program write collides with a bus write to the same address.
    prog_we = 1; prog_addr = 4'h0; prog_data = 8'h77; ram_latch = 1; a_reg_out = 1;
    tick();
    clr_ctrl();
    peek_ram("write_collision", 8'h77);

    // Halt suppresses latches on its own edge and afterwards.
    load_a(8'h10);
    counter_enable = 1;
    tick();
    clr_ctrl();
    prog_write(4'h0, 8'h33);
    halt = 1; a_reg_latch = 1; ram_out = 1; counter_enable = 1;
    tick();
    clr_ctrl();
    expect_now("halt_set", 8'h01, 8'(halted));
    peek_a("halt_A_kept", 8'h10);
    peek_pc("halt_PC_kept", 8'h01);
    counter_enable = 1; ram_out = 1; output_latch = 1;
    tick();
    clr_ctrl();
    expect_now("halt_sticky", 8'h01, 8'(halted));
    peek_pc("halted_PC_frozen", 8'h01);
    expect_now("halted_out_kept", 8'h55, out_value);
    prog_write(4'h0, 8'h99);
    peek_ram("halted_prog_we", 8'h99);
    reset = 1;
    tick();
    reset = 0; #1;
    expect_now("reset_clears_halt", 8'h00, 8'(halted));
    peek_pc("reset_PC", 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
